// File: rtl/serial_operand_tx.sv
// serial_operand_tx: accepts a parallel operand pair over valid/ready and emits it LSB-first
// as a serial vld/a/b/last stream, one bit pair per unheld cycle.
// Optional feature: define SERIAL_OPERAND_TX_SUM_CAPTURE_EN to add the sum input and the
// res/res_vld capture of the adder's serial sum back into a parallel word.
module serial_operand_tx #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic             hold,
  output logic             vld,
  output logic             a,
  output logic             b,
`ifdef SERIAL_OPERAND_TX_SUM_CAPTURE_EN
  input  logic             sum,
  output logic [WIDTH-1:0] res,
  output logic             res_vld,
`endif
  output logic             last
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // State register for the FSM, operand shifters and bit counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and serial outputs; a new word may load on the last-bit cycle for zero gap.
  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    up_rdy  = 1'b0;
    vld     = 1'b0;
    a       = 1'b0;
    b       = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gate with reset so ready is low throughout reset assertion.
        up_rdy = rst;
        if (up_vld) begin
          sh_a_d  = up_a;
          sh_b_d  = up_b;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        vld  = ~hold;
        a    = vld & sh_a_q[0];
        b    = vld & sh_b_q[0];
        last = vld && (cnt_q == CntLast);
        if (vld && !last) begin
          sh_a_d = sh_a_q >> 1;
          sh_b_d = sh_b_q >> 1;
          cnt_d  = cnt_q + CntW'(1);
        end else if (last) begin
          up_rdy = 1'b1;
          if (up_vld) begin
            sh_a_d = up_a;
            sh_b_d = up_b;
            cnt_d  = '0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef SERIAL_OPERAND_TX_SUM_CAPTURE_EN
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_vld_q, res_vld_d;
  logic [WIDTH-1:0] res_sh_nxt;

  // Sum bits arrive LSB-first, so each new bit enters at the top and the word shifts down.
  always_comb begin
    res_sh_nxt = (res_sh_q >> 1) | (WIDTH'(sum) << (WIDTH - 1));
    res_sh_d   = res_sh_q;
    res_d      = res_q;
    res_vld_d  = 1'b0;
    if (vld) begin
      res_sh_d = res_sh_nxt;
    end
    if (last) begin
      res_d     = res_sh_nxt;
      res_vld_d = 1'b1;
    end
  end

  // Capture registers; res holds until the next completed word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_sh_q  <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      res_sh_q  <= res_sh_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign res     = res_q;
  assign res_vld = res_vld_q;
`endif

endmodule

// File: tb/tb_serial_operand_tx.sv
// Directed bench for serial_operand_tx at WIDTH=4 and WIDTH=1, with a behavioural serial
// adder closing the loop when SERIAL_OPERAND_TX_SUM_CAPTURE_EN is defined.
module tb_serial_operand_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  // WIDTH=4 instance signals
  logic       up_vld = 1'b0;
  logic       up_rdy;
  logic [3:0] up_a = '0;
  logic [3:0] up_b = '0;
  logic       hold = 1'b0;
  logic       vld, a, b, last;

  // WIDTH=1 instance signals
  logic       up_vld1 = 1'b0;
  logic       up_rdy1;
  logic [0:0] up_a1 = '0;
  logic [0:0] up_b1 = '0;
  logic       vld1, a1, b1, last1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

`ifdef SERIAL_OPERAND_TX_SUM_CAPTURE_EN
  logic       sum, sum1, c_q, c1_q;
  logic [3:0] res;
  logic [0:0] res1;
  logic       res_vld, res_vld1;

  // Reference serial adder: carry clears after each word's last bit.
  assign sum  = a ^ b ^ c_q;
  assign sum1 = a1 ^ b1 ^ c1_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q  <= 1'b0;
      c1_q <= 1'b0;
    end else begin
      if (vld)  c_q  <= last  ? 1'b0 : ((a & b) | (a & c_q) | (b & c_q));
      if (vld1) c1_q <= last1 ? 1'b0 : ((a1 & b1) | (a1 & c1_q) | (b1 & c1_q));
    end
  end
`endif

  serial_operand_tx #(.WIDTH(4)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .up_vld  (up_vld),
    .up_rdy  (up_rdy),
    .up_a    (up_a),
    .up_b    (up_b),
    .hold    (hold),
    .vld     (vld),
    .a       (a),
    .b       (b),
`ifdef SERIAL_OPERAND_TX_SUM_CAPTURE_EN
    .sum     (sum),
    .res     (res),
    .res_vld (res_vld),
`endif
    .last    (last)
  );

  serial_operand_tx #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .up_vld  (up_vld1),
    .up_rdy  (up_rdy1),
    .up_a    (up_a1),
    .up_b    (up_b1),
    .hold    (1'b0),
    .vld     (vld1),
    .a       (a1),
    .b       (b1),
`ifdef SERIAL_OPERAND_TX_SUM_CAPTURE_EN
    .sum     (sum1),
    .res     (res1),
    .res_vld (res_vld1),
`endif
    .last    (last1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of WIDTH=4 inputs, check {vld,a,b,last,up_rdy} mid-cycle, step an edge.
  task automatic step(input string tag, input logic uv, input logic [3:0] ua,
                      input logic [3:0] ub, input logic h, input logic [4:0] exp);
    up_vld = uv;
    up_a   = ua;
    up_b   = ub;
    hold   = h;
    @(negedge clk);
    check_eq(tag, {27'd0, vld, a, b, last, up_rdy}, {27'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input string tag, input logic uv, input logic ua, input logic ub,
                       input logic [4:0] exp);
    up_vld1  = uv;
    up_a1[0] = ua;
    up_b1[0] = ub;
    @(negedge clk);
    check_eq(tag, {27'd0, vld1, a1, b1, last1, up_rdy1}, {27'd0, exp});
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1 right after a last-bit edge of the WIDTH=4 instance.
  task automatic check_res(input string tag, input logic [3:0] exp);
`ifdef SERIAL_OPERAND_TX_SUM_CAPTURE_EN
    check_eq({tag, "_res_vld"}, {31'd0, res_vld}, 32'd1);
    check_eq({tag, "_res"}, {28'd0, res}, {28'd0, exp});
`endif
  endtask

  task automatic check_res_low(input string tag);
`ifdef SERIAL_OPERAND_TX_SUM_CAPTURE_EN
    check_eq({tag, "_res_vld_low"}, {31'd0, res_vld}, 32'd0);
`endif
  endtask

  initial begin
    #2;
    check_eq("rst_outs", {27'd0, vld, a, b, last, up_rdy}, 32'd0);
    check_eq("rst_outs1", {27'd0, vld1, a1, b1, last1, up_rdy1}, 32'd0);
    check_res_low("rst");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: 6+3, bits a 0,1,1,0 b 1,1,0,0
    step("t1_idle", 1'b1, 4'd6, 4'd3, 1'b0, 5'b00001);
    step("t1_b0", 1'b0, 4'd0, 4'd0, 1'b0, 5'b10100);
    step("t1_b1", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11100);
    step("t1_b2", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11000);
    step("t1_b3", 1'b0, 4'd0, 4'd0, 1'b0, 5'b10011);
    check_res("t1", 4'd9);
    step("t1_after", 1'b0, 4'd0, 4'd0, 1'b0, 5'b00001);
    check_res_low("t1");

    // 2: (5,2) then (7,7) back-to-back with up_vld held
    step("t2_idle", 1'b1, 4'd5, 4'd2, 1'b0, 5'b00001);
    step("t2_w0b0", 1'b1, 4'd7, 4'd7, 1'b0, 5'b11000);
    step("t2_w0b1", 1'b1, 4'd7, 4'd7, 1'b0, 5'b10100);
    step("t2_w0b2", 1'b1, 4'd7, 4'd7, 1'b0, 5'b11000);
    step("t2_w0b3", 1'b1, 4'd7, 4'd7, 1'b0, 5'b10011);
    check_res("t2_w0", 4'd7);
    step("t2_w1b0", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11100);
    check_res_low("t2_w1b0");
    step("t2_w1b1", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11100);
    step("t2_w1b2", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11100);
    step("t2_w1b3", 1'b0, 4'd0, 4'd0, 1'b0, 5'b10011);
    check_res("t2_w1", 4'd14);

    // 3: (9,4) with hold on bit 1; a 1,0,0,1 b 0,0,1,0
    step("t3_idle", 1'b1, 4'd9, 4'd4, 1'b0, 5'b00001);
    step("t3_b0", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11000);
    step("t3_hold", 1'b0, 4'd0, 4'd0, 1'b1, 5'b00000);
    step("t3_b1", 1'b0, 4'd0, 4'd0, 1'b0, 5'b10000);
    step("t3_b2", 1'b0, 4'd0, 4'd0, 1'b0, 5'b10100);
    step("t3_b3", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11011);
    check_res("t3", 4'd13);

    // 3b: (9,4) with hold on the last bit: last and up_rdy deferred
    step("t3b_idle", 1'b1, 4'd9, 4'd4, 1'b0, 5'b00001);
    step("t3b_b0", 1'b1, 4'd1, 4'd1, 1'b0, 5'b11000);
    step("t3b_b1", 1'b1, 4'd1, 4'd1, 1'b0, 5'b10000);
    step("t3b_b2", 1'b1, 4'd1, 4'd1, 1'b0, 5'b10100);
    step("t3b_hold", 1'b1, 4'd1, 4'd1, 1'b1, 5'b00000);
    check_res_low("t3b_hold");
    step("t3b_b3", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11011);
    check_res("t3b", 4'd13);

    // 4: reset after two bits of (3,3)
    step("t4_idle", 1'b1, 4'd3, 4'd3, 1'b0, 5'b00001);
    step("t4_b0", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11100);
    step("t4_b1", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11100);
    rst = 1'b0;
    #1;
    check_eq("t4_rst_outs", {27'd0, vld, a, b, last, up_rdy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_res_low("t4_in_rst");
    end
    @(posedge clk);
    #1 rst = 1'b1;
    step("t4_idle2", 1'b1, 4'd1, 4'd1, 1'b0, 5'b00001);
    step("t4_b0n", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11100);
    step("t4_b1n", 1'b0, 4'd0, 4'd0, 1'b0, 5'b10000);
    step("t4_b2n", 1'b0, 4'd0, 4'd0, 1'b0, 5'b10000);
    step("t4_b3n", 1'b0, 4'd0, 4'd0, 1'b0, 5'b10011);
    check_res("t4", 4'd2);

    // 5: overflow 15+1 wraps to 0
    step("t5_idle", 1'b1, 4'd15, 4'd1, 1'b0, 5'b00001);
    step("t5_b0", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11100);
    step("t5_b1", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11000);
    step("t5_b2", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11000);
    step("t5_b3", 1'b0, 4'd0, 4'd0, 1'b0, 5'b11011);
    check_res("t5", 4'd0);
    step("t5_after", 1'b0, 4'd0, 4'd0, 1'b0, 5'b00001);
    check_res_low("t5");

    // 6: WIDTH=1, 1+1 then 0+1 back-to-back
    step1("t6_idle", 1'b1, 1'b1, 1'b1, 5'b00001);
    step1("t6_w0", 1'b1, 1'b0, 1'b1, 5'b11111);
`ifdef SERIAL_OPERAND_TX_SUM_CAPTURE_EN
    check_eq("t6_w0_res_vld", {31'd0, res_vld1}, 32'd1);
    check_eq("t6_w0_res", {31'd0, res1}, 32'd0);
`endif
    step1("t6_w1", 1'b0, 1'b0, 1'b0, 5'b10111);
`ifdef SERIAL_OPERAND_TX_SUM_CAPTURE_EN
    check_eq("t6_w1_res_vld", {31'd0, res_vld1}, 32'd1);
    check_eq("t6_w1_res", {31'd0, res1}, 32'd1);
`endif
    step1("t6_after", 1'b0, 1'b0, 1'b0, 5'b00001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
